// File: rtl/msm_accumulator.sv
// msm_accumulator: buffers finished k_i*P_i products in a small FIFO and folds
// them one by one into a running batch sum. The point addition is done by an
// external adder driven over a start/done handshake. At the end of a batch the
// total and term count are presented until the consumer takes them.
// Optional feature macro: MSM_ACC_DOUBLE_DETECT_EN flags equal operands so the
// adder wrapper can route them to the point doubler.

package msm_acc_pkg;
  localparam int COORD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } curve_point_t;
endpackage

module msm_accumulator
  import msm_acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  curve_point_t       i_in_point,
  input  logic               i_in_last,
  output logic               o_add_start,
  output logic               o_add_double,
  output curve_point_t       o_add_a,
  output curve_point_t       o_add_b,
  input  logic               i_add_done,
  input  curve_point_t       i_add_sum,
  output logic               o_sum_valid,
  input  logic               i_sum_ready,
  output curve_point_t       o_sum_point,
  output logic [CNT_W-1:0]   o_sum_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t             r_state;
  curve_point_t       r_fifoPoint [DEPTH];
  logic               r_fifoLast  [DEPTH];
  logic [AW:0]        r_wrPtr;
  logic [AW:0]        r_rdPtr;
  curve_point_t       r_acc;
  logic               r_accEmpty;
  logic [CNT_W-1:0]   r_count;
  logic               r_last;
  logic               r_addStart;
  curve_point_t       r_addA;
  curve_point_t       r_addB;
  logic               r_sumValid;
  curve_point_t       r_sumPoint;
  logic [CNT_W-1:0]   r_sumCount;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  curve_point_t       w_headPoint;
  logic               w_headLast;

  // The extra wrap bit on each pointer separates full from empty when the
  // index bits match.
  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_full      = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                       (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_push      = i_in_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_headPoint = r_fifoPoint[r_rdPtr[AW-1:0]];
  assign w_headLast  = r_fifoLast[r_rdPtr[AW-1:0]];

  assign o_in_ready  = !w_full;
  assign o_add_start = r_addStart;
  assign o_add_a     = r_addA;
  assign o_add_b     = r_addB;
  assign o_sum_valid = r_sumValid;
  assign o_sum_point = r_sumPoint;
  assign o_sum_count = r_sumCount;

  // FIFO storage: contents need no reset, emptiness lives in the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoPoint[r_wrPtr[AW-1:0]] <= i_in_point;
      r_fifoLast[r_wrPtr[AW-1:0]]  <= i_in_last;
    end
  end

  // FIFO pointers: a push is refused whenever full, even if a pop happens in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

`ifdef MSM_ACC_DOUBLE_DETECT_EN
  logic r_dblPending;
  logic r_addDouble;
  assign o_add_double = r_addDouble;

  // Equality of accumulator and term is decided at pop time and released together with add_start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dblPending <= 1'b0;
      r_addDouble  <= 1'b0;
    end else begin
      if (w_pop && !r_accEmpty) r_dblPending <= (r_acc == w_headPoint);
      if (r_state == S_ISSUE)   r_addDouble  <= r_dblPending;
      else                      r_addDouble  <= 1'b0;
    end
  end
`else
  assign o_add_double = 1'b0;
`endif

  // Batch sequencer: pops terms, launches the external adder, and holds the total until accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_accEmpty <= 1'b1;
      r_count    <= '0;
      r_last     <= 1'b0;
      r_addStart <= 1'b0;
      r_addA     <= '0;
      r_addB     <= '0;
      r_sumValid <= 1'b0;
      r_sumPoint <= '0;
      r_sumCount <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_count <= (r_count == '1) ? r_count : r_count + CNT_W'(1);
            r_last  <= w_headLast;
            if (r_accEmpty) begin
              r_acc      <= w_headPoint;
              r_accEmpty <= 1'b0;
              r_state    <= w_headLast ? S_OUTPUT : S_IDLE;
            end else begin
              r_addA  <= r_acc;
              r_addB  <= w_headPoint;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_addStart <= 1'b1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_addStart <= 1'b0;
          if (i_add_done && !r_addStart) begin
            r_acc   <= i_add_sum;
            r_state <= r_last ? S_OUTPUT : S_IDLE;
          end
        end
        S_OUTPUT: begin
          if (!r_sumValid) begin
            r_sumValid <= 1'b1;
            r_sumPoint <= r_acc;
            r_sumCount <= r_count;
          end else if (i_sum_ready) begin
            r_sumValid <= 1'b0;
            r_accEmpty <= 1'b1;
            r_count    <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
